// File: rtl/adc_auto_calib.sv
// adc_auto_calib
//   Automatic IDELAY/ISERDES calibration for one ADC receiver lane. While the
//   ADC transmits its training word, the engine sweeps all 32 IDELAY taps. It
//   grades each tap as stable or unstable and keeps the widest run of stable
//   taps, where the earliest run wins a tie. It then loads the floor centre of
//   that run and issues bitslips until the deserialized word matches the
//   training pattern.
//
//   Optional feature: define ADC_AUTO_CALIB_READBACK_EN to compare the IDELAY
//   tap readback with the loaded tap on the last settle cycle after every
//   load. A mismatch aborts with fail code 3. Without the macro, the readback
//   input is ignored.
//
// Ports
//   clk_i          lane clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        single-cycle calibration request (ignored while busy)
//   data_i         ISERDES word, one per clock
//   dl_cnt_val_i   IDELAY tap readback
//   dl_cnt_in_o    tap value to load
//   dl_load_val_o  one-cycle IDELAY load strobe
//   bitslip_o      one-cycle ISERDES bitslip strobe
//   busy_o         calibration in progress
//   done_o/fail_o  sticky result flags, cleared by the next start or reset
//   fail_code_o    0 none, 1 no eye, 2 slips exhausted, 3 readback mismatch
//   eye_start_o    first tap of the chosen eye
//   eye_width_o    length of the chosen eye (0..32)
module adc_auto_calib #(
  parameter int unsigned       DATA_W        = 8,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hA5,
  parameter int unsigned       SETTLE_CYC    = 8,
  parameter int unsigned       CHECK_CYC     = 16,
  parameter int unsigned       MIN_EYE       = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [4:0]        dl_cnt_val_i,
  output logic [4:0]        dl_cnt_in_o,
  output logic              dl_load_val_o,
  output logic              bitslip_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [1:0]        fail_code_o,
  output logic [4:0]        eye_start_o,
  output logic [5:0]        eye_width_o
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CHECK_LAST  = CW'(CHECK_CYC - 1);
  localparam logic [SW-1:0] SLIP_LAST   = SW'(DATA_W - 1);
  localparam logic [5:0]    MIN_EYE_W   = 6'(MIN_EYE);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_CENTER, S_CSETTLE,
    S_SLIP_CHECK, S_SLIP, S_SSETTLE, S_DONE, S_FAIL
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [4:0]        tap_q;
  logic [DATA_W-1:0] ref_q;
  logic              good_q;
  logic [5:0]        cur_len_q;
  logic [4:0]        cur_start_q;
  logic [5:0]        best_len_q;
  logic [4:0]        best_start_q;
  logic [SW-1:0]     slip_cnt_q;
  logic [4:0]        dl_cnt_in_q;
  logic              dl_load_q;
  logic              bitslip_q;
  logic              busy_q;
  logic              done_q;
  logic              fail_q;
  logic [1:0]        fail_code_q;

  // A word is acceptable as a reference if any rotation of the training
  // pattern matches it. The bitslip phase fixes the rotation later.
  function automatic logic is_rotation(input logic [DATA_W-1:0] w);
    logic              hit;
    logic [DATA_W-1:0] r;
    hit = 1'b0;
    r   = TRAIN_PATTERN;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (w == r) hit = 1'b1;
      r = {r[DATA_W-2:0], r[DATA_W-1]};
    end
    return hit;
  endfunction

  logic rb_mismatch;
`ifdef ADC_AUTO_CALIB_READBACK_EN
  assign rb_mismatch = (dl_cnt_val_i != dl_cnt_in_q);
`else
  logic unused_rb;
  assign rb_mismatch = 1'b0;
  assign unused_rb   = ^dl_cnt_val_i;
`endif

  // Run tracking for the EVAL cycle. The fin_* values are the best run once
  // this tap has been accounted for. On tap 31 they include the run that is
  // still open.
  logic [5:0] run_len;
  logic [4:0] run_start;
  logic       close_run;
  logic       take_best;
  logic [5:0] fin_len;
  logic [4:0] fin_start;
  logic [4:0] centre;

  always_comb begin
    run_len   = good_q ? (cur_len_q + 6'd1) : cur_len_q;
    run_start = (good_q && cur_len_q == 6'd0) ? tap_q : cur_start_q;
    close_run = !good_q || (tap_q == 5'd31);
    take_best = close_run && (run_len > best_len_q);
    fin_len   = take_best ? run_len   : best_len_q;
    fin_start = take_best ? run_start : best_start_q;
    centre    = fin_start + fin_len[5:1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      ref_q        <= '0;
      good_q       <= 1'b0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      slip_cnt_q   <= '0;
      dl_cnt_in_q  <= '0;
      dl_load_q    <= 1'b0;
      bitslip_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= 2'd0;
    end else begin
      // Strobes are high only in the cycle after they are set.
      dl_load_q <= 1'b0;
      bitslip_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_i) begin
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= 2'd0;
            tap_q        <= '0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            slip_cnt_q   <= '0;
            dl_cnt_in_q  <= '0;
            dl_load_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE, S_CSETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q <= '0;
            if (rb_mismatch) begin
              busy_q      <= 1'b0;
              fail_q      <= 1'b1;
              fail_code_q <= 2'd3;
              state_q     <= S_FAIL;
            end else begin
              state_q <= (state_q == S_SETTLE) ? S_CHECK : S_SLIP_CHECK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (cnt_q == '0) begin
            ref_q  <= data_i;
            good_q <= is_rotation(data_i);
          end else if (data_i != ref_q) begin
            good_q <= 1'b0;
          end
          if (cnt_q == CHECK_LAST) state_q <= S_EVAL;
          else                     cnt_q   <= cnt_q + 1'b1;
        end
        S_EVAL: begin
          if (close_run) begin
            cur_len_q <= '0;
            if (take_best) begin
              best_len_q   <= run_len;
              best_start_q <= run_start;
            end
          end else begin
            cur_len_q   <= run_len;
            cur_start_q <= run_start;
          end
          if (tap_q != 5'd31) begin
            tap_q       <= tap_q + 5'd1;
            dl_cnt_in_q <= tap_q + 5'd1;
            dl_load_q   <= 1'b1;
            state_q     <= S_LOAD;
          end else if (fin_len < MIN_EYE_W) begin
            // The no-eye verdict is taken here so that the failure lands
            // directly after the last swept tap.
            busy_q      <= 1'b0;
            fail_q      <= 1'b1;
            fail_code_q <= 2'd1;
            state_q     <= S_FAIL;
          end else begin
            // CENTER is the load cycle for the centre tap.
            tap_q       <= centre;
            dl_cnt_in_q <= centre;
            dl_load_q   <= 1'b1;
            state_q     <= S_CENTER;
          end
        end
        S_CENTER: begin
          cnt_q   <= '0;
          state_q <= S_CSETTLE;
        end
        S_SLIP_CHECK: begin
          if (data_i == TRAIN_PATTERN) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (slip_cnt_q == SLIP_LAST) begin
            busy_q      <= 1'b0;
            fail_q      <= 1'b1;
            fail_code_q <= 2'd2;
            state_q     <= S_FAIL;
          end else begin
            slip_cnt_q <= slip_cnt_q + 1'b1;
            bitslip_q  <= 1'b1;
            state_q    <= S_SLIP;
          end
        end
        S_SLIP: begin
          cnt_q   <= '0;
          state_q <= S_SSETTLE;
        end
        S_SSETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SLIP_CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dl_cnt_in_o   = dl_cnt_in_q;
  assign dl_load_val_o = dl_load_q;
  assign bitslip_o     = bitslip_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;
  assign fail_code_o   = fail_code_q;
  assign eye_start_o   = best_start_q;
  assign eye_width_o   = best_len_q;

endmodule
